// File: rtl/mouse_state_cdc.sv
// mouse_state_cdc: carries {x, y, buttons} from clk100MHz to clk40MHz over a toggle req/ack handshake,
// clamps to the screen, emits press/release pulses and counts samples lost to back-pressure.
module mouse_state_cdc #(
    parameter int W           = 12,
    parameter int BTN_N       = 3,
    parameter int MAX_X       = 799,
    parameter int MAX_Y       = 599,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk40MHz,
    input  logic             rst,
    input  logic             clk100MHz,
    input  logic [W-1:0]     src_x,
    input  logic [W-1:0]     src_y,
    input  logic [BTN_N-1:0] src_btn,
    input  logic             src_valid,
    output logic [W-1:0]     x,
    output logic [W-1:0]     y,
    output logic [BTN_N-1:0] btn,
    output logic [BTN_N-1:0] press,
    output logic [BTN_N-1:0] release_pulse,
    output logic             update,
    output logic [7:0]       drop_cnt
);
    localparam int SW = 2*W + BTN_N;
    localparam int PW = SW + 8;
    localparam logic [0:0] IDLE = 1'b0, WAIT_ACK = 1'b1;

    logic [SYNC_STAGES-1:0] rst_sync, ack_sync, req_sync;
    logic [0:0]  state;
    logic        req, pending, ack, req_seen, src_rst, acked, new_req;
    logic [7:0]  drop, drop_next;
    logic [SW-1:0] src_word, pend_word, next_word;
    logic [PW-1:0] launch;
    logic [W-1:0]  lx, ly;
    logic [BTN_N-1:0] lb;

    assign src_rst   = rst_sync[SYNC_STAGES-1];
    assign acked     = ack_sync[SYNC_STAGES-1] == req;
    assign src_word  = {src_x, src_y, src_btn};
    assign next_word = src_valid ? src_word : pend_word;
    // an overwrite is any new sample landing on an already-pending one
    assign drop_next = (src_valid && pending && drop != 8'hff) ? drop + 8'd1 : drop;

    always_ff @(posedge clk100MHz)
        rst_sync <= {rst_sync[SYNC_STAGES-2:0], rst};

    always_ff @(posedge clk100MHz) begin
        if (src_rst) begin
            state    <= IDLE;
            req      <= 1'b0;
            pending  <= 1'b0;
            drop     <= 8'd0;
            ack_sync <= '0;
        end else begin
            ack_sync <= {ack_sync[SYNC_STAGES-2:0], ack};
            drop     <= drop_next;
            if (state == IDLE) begin
                if (src_valid) begin
                    launch <= {src_word, drop};
                    req    <= ~req;
                    state  <= WAIT_ACK;
                end
            end else if (acked) begin
                // a sample arriving on the ack cycle is launched directly so it cannot be lost
                if (pending || src_valid) begin
                    launch  <= {next_word, drop_next};
                    req     <= ~req;
                    pending <= 1'b0;
                end else begin
                    state <= IDLE;
                end
            end else if (src_valid) begin
                pend_word <= src_word;
                pending   <= 1'b1;
            end
        end
    end

    assign new_req = req_sync[SYNC_STAGES-1] != req_seen;
    assign lx = launch[PW-1 -: W];
    assign ly = launch[PW-W-1 -: W];
    assign lb = launch[8 +: BTN_N];

    always_ff @(posedge clk40MHz) begin
        if (rst) begin
            req_sync      <= '0;
            req_seen      <= 1'b0;
            ack           <= 1'b0;
            update        <= 1'b0;
            x             <= '0;
            y             <= '0;
            btn           <= '0;
            press         <= '0;
            release_pulse <= '0;
            drop_cnt      <= 8'd0;
        end else begin
            req_sync      <= {req_sync[SYNC_STAGES-2:0], req};
            update        <= new_req;
            press         <= new_req ? lb & ~btn : '0;
            release_pulse <= new_req ? ~lb & btn : '0;
            if (new_req) begin
                req_seen <= req_sync[SYNC_STAGES-1];
                ack      <= ~ack;
                x        <= lx > W'(MAX_X) ? W'(MAX_X) : lx;
                y        <= ly > W'(MAX_Y) ? W'(MAX_Y) : ly;
                btn      <= lb;
                drop_cnt <= launch[7:0];
            end
        end
    end
endmodule

// File: tb/tb_mouse_state_cdc.sv
// tb_mouse_state_cdc: directed and random samples checked against a per-sample reference model.
module tb_mouse_state_cdc;
    localparam int W = 12, BTN_N = 3, MAX_X = 799, MAX_Y = 599, S = 2;

    logic clk40MHz = 1'b0, clk100MHz = 1'b0, rst = 1'b1, run40 = 1'b1;
    logic [W-1:0] src_x = '0, src_y = '0, x, y;
    logic [BTN_N-1:0] src_btn = '0, btn, press, release_pulse;
    logic src_valid = 1'b0, update;
    logic [7:0] drop_cnt;

    typedef struct {int x; int y; int btn; int press; int rel; int drop;} rec_t;
    rec_t q[$];
    int first_idx;
    int checks = 0, errors = 0;
    int prev_btn = 0;

    mouse_state_cdc #(.W(W), .BTN_N(BTN_N), .MAX_X(MAX_X), .MAX_Y(MAX_Y), .SYNC_STAGES(S)) dut (
        .clk40MHz(clk40MHz), .rst(rst), .clk100MHz(clk100MHz),
        .src_x(src_x), .src_y(src_y), .src_btn(src_btn), .src_valid(src_valid),
        .x(x), .y(y), .btn(btn), .press(press), .release_pulse(release_pulse),
        .update(update), .drop_cnt(drop_cnt)
    );

    always #5 clk100MHz = ~clk100MHz;
    always #12 clk40MHz = run40 ? ~clk40MHz : 1'b0;

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic send(input int sx, input int sy, input int sb);
        @(negedge clk100MHz);
        src_x = W'(sx); src_y = W'(sy); src_btn = BTN_N'(sb); src_valid = 1'b1;
        @(negedge clk100MHz);
        src_valid = 1'b0;
    endtask

    task automatic collect(input int ncyc);
        logic pu;
        rec_t r;
        pu = 1'b0;
        q.delete();
        first_idx = -1;
        for (int i = 1; i <= ncyc; i++) begin
            @(negedge clk40MHz);
            if (update) begin
                r = '{int'(x), int'(y), int'(btn), int'(press), int'(release_pulse), int'(drop_cnt)};
                q.push_back(r);
                if (first_idx < 0) first_idx = i;
            end else if (pu) begin
                chk("press_width", press, 0);
                chk("release_width", release_pulse, 0);
            end
            pu = update;
        end
    endtask

    // reference: clamp, edge-detect against last delivered buttons, carry expected drop count
    task automatic check_rec(input string tag, input int idx, input int sx, input int sy, input int sb, input int sd);
        if (q.size() > idx) begin
            chk({tag, "_x"}, q[idx].x, sx > MAX_X ? MAX_X : sx);
            chk({tag, "_y"}, q[idx].y, sy > MAX_Y ? MAX_Y : sy);
            chk({tag, "_btn"}, q[idx].btn, sb);
            chk({tag, "_press"}, q[idx].press, sb & ~prev_btn & 7);
            chk({tag, "_release"}, q[idx].rel, ~sb & prev_btn & 7);
            chk({tag, "_drop"}, q[idx].drop, sd);
        end
        prev_btn = sb;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_x"}, x, 0);
        chk({tag, "_y"}, y, 0);
        chk({tag, "_btn"}, btn, 0);
        chk({tag, "_press"}, press, 0);
        chk({tag, "_release"}, release_pulse, 0);
        chk({tag, "_update"}, update, 0);
        chk({tag, "_drop"}, drop_cnt, 0);
    endtask

    initial begin
        int bseq[3];
        int rx, ry, rb;
        bseq = '{1, 3, 2};
        repeat (6) @(posedge clk40MHz);
        @(negedge clk40MHz);
        check_zero("reset");
        rst = 1'b0;
        repeat (5) @(negedge clk40MHz);

        send(100, 200, 0);
        collect(12);
        chk("single_count", q.size(), 1);
        chk("single_latency", first_idx >= 1 && first_idx <= S + 3, 1);
        check_rec("single", 0, 100, 200, 0, 0);

        send(1023, 4095, 0);
        collect(12);
        chk("clamp_count", q.size(), 1);
        check_rec("clamp", 0, 1023, 4095, 0, 0);
        send(799, 599, 0);
        collect(12);
        chk("edge_count", q.size(), 1);
        check_rec("edge", 0, 799, 599, 0, 0);

        @(negedge clk100MHz);
        for (int v = 1; v <= 5; v++) begin
            src_x = W'(v); src_y = W'(v * 10); src_btn = '0; src_valid = 1'b1;
            @(negedge clk100MHz);
        end
        src_valid = 1'b0;
        collect(40);
        chk("burst_count", q.size(), 2);
        check_rec("burst_first", 0, 1, 10, 0, 0);
        check_rec("burst_last", 1, 5, 50, 0, 3);

        foreach (bseq[i]) begin
            send(10, 20, bseq[i]);
            collect(12);
            chk("btn_count", q.size(), 1);
            check_rec("btn", 0, 10, 20, bseq[i], 3);
        end

        send(300, 5, 0);
        rst = 1'b1;
        repeat (5) @(posedge clk40MHz);
        @(negedge clk40MHz);
        rst = 1'b0;
        collect(20);
        chk("midrst_count", q.size(), 0);
        check_zero("midrst");
        prev_btn = 0;
        send(50, 60, 0);
        collect(12);
        chk("after_rst_count", q.size(), 1);
        check_rec("after_rst", 0, 50, 60, 0, 0);

        for (int n = 0; n < 16; n++) begin
            rx = $urandom_range(0, 4095);
            ry = $urandom_range(0, 4095);
            rb = $urandom_range(0, 7);
            send(rx, ry, rb);
            collect(12);
            chk("rand_count", q.size(), 1);
            check_rec("rand", 0, rx, ry, rb, 0);
        end

        @(negedge clk40MHz);
        run40 = 1'b0;
        @(negedge clk100MHz);
        for (int i = 0; i < 302; i++) begin
            src_x = W'(i); src_y = W'(i); src_btn = BTN_N'(i % 8); src_valid = 1'b1;
            @(negedge clk100MHz);
        end
        src_valid = 1'b0;
        run40 = 1'b1;
        collect(60);
        chk("sat_count", q.size(), 2);
        check_rec("sat_first", 0, 0, 0, 0, 0);
        check_rec("sat_last", 1, 301, 301, 301 % 8, 255);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mouse_state_cdc.md
Name: mouse_state_cdc

Overview:
- Parametrised successor to the team's mouse position resampler.
- Moves a mouse sample {x, y, buttons} from the PS/2 decoder domain (clk100MHz) into the pixel domain (clk40MHz) with a toggle req/ack handshake, replacing direct multi-bit resampling.
- Clamps coordinates to the screen, produces button press/release pulses and counts samples lost to back-pressure.
- Sits between the PS/2 mouse decoder and the cursor/draw logic.

Parameters:
- W, 12: coordinate width.
- BTN_N, 3: number of buttons (left, middle, right).
- MAX_X, 799: largest legal x output.
- MAX_Y, 599: largest legal y output.
- SYNC_STAGES, 2: synchroniser depth in each direction (≥2).

Ports:
- clk40MHz  in  1  destination clock.
- rst  in  1  reset, synchronous, active-high, clk40MHz domain. Held ≥4 clk40MHz cycles.
- clk100MHz  in  1  source clock.
- src_x  in  W  decoder x position (clk100MHz).
- src_y  in  W  decoder y position (clk100MHz).
- src_btn  in  BTN_N  decoder button levels (clk100MHz).
- src_valid  in  1  one-cycle new-sample strobe (clk100MHz).
- x  out  W  clamped x.
- y  out  W  clamped y.
- btn  out  BTN_N  button levels.
- press  out  BTN_N  one-cycle pulse per button on 0→1.
- release  out  BTN_N  one-cycle pulse per button on 1→0.
- update  out  1  one-cycle pulse when a new sample is committed.
- drop_cnt  out  8  saturating count of overwritten source samples.

Behaviour:
- Source reset: rst passes through a SYNC_STAGES synchroniser into clk100MHz. The synchronised copy clears req, pending, drop counter and the FSM.
- Source FSM, state IDLE:
  - On src_valid: load payload {src_x, src_y, src_btn, drop} into the launch register, toggle req, go to WAIT_ACK.
- Source FSM, state WAIT_ACK:
  - Launch register is frozen.
  - On src_valid: write the sample into the pending slot and set pending. If pending was already set, drop += 1 (saturate at 255).
  - On ack_sync == req:
    - If pending: move pending into the launch register (with current drop, including any increment in the same cycle), clear pending, toggle req, stay in WAIT_ACK.
    - Otherwise: go to IDLE.
- ack is synchronised into clk100MHz through SYNC_STAGES flops.
- Destination side:
  - req is synchronised through SYNC_STAGES flops.
  - When req_sync != req_seen:
    - capture the launch register (stable by construction);
    - set req_seen = req_sync;
    - toggle ack;
    - assert update in the next cycle.
- Output update, registered with the update pulse:
  - x = min(payload_x, MAX_X); y = min(payload_y, MAX_Y), unsigned.
  - btn = payload_btn.
  - press = payload_btn & ~btn_old; release = ~payload_btn & btn_old.
  - drop_cnt = payload drop.
- press and release are 0 in every cycle without update.
- Latency, src_valid in IDLE to update: 1 clk100MHz cycle + SYNC_STAGES+1 to SYNC_STAGES+2 clk40MHz cycles.
- Round trip before the next launch: ≤ 2·SYNC_STAGES+4 cycles of the slower clock.
- Last-value-wins: the final sample of any burst is always delivered. Intermediate samples may be overwritten, and each overwrite increments drop.
- Reset values: x=0, y=0, btn=0, press=0, release=0, update=0, drop_cnt=0, ack=0, req_seen=0, all synchroniser flops 0.
- Reset mid-transfer: both toggles return to 0. The in-flight sample is discarded and no update is produced for it. The rst hold requirement guarantees the source req is 0 before the destination leaves reset, so no spurious edge is seen.
- Outputs hold their value between updates. No combinational path from any src_* input to any output.

Test Plan:
- Single sample: src_x=100, src_y=200, src_btn=0 pulsed once → exactly one update within SYNC_STAGES+3 clk40MHz cycles; x=100, y=200, btn=0, drop_cnt=0.
- Clamp: src_x=1023, src_y=4095 → x=799, y=599. Then src_x=799, src_y=599 → unchanged 799/599.
- Burst: 5 src_valid on consecutive clk100MHz cycles with x=1..5:
  - first update x=1; final update x=5;
  - drop_cnt on the final update = 3 (samples 2, 3, 4 overwritten);
  - 5 must never be lost.
- Buttons: btn 000→001→011→010, one sample each spaced apart →
  - press pulses 001, 010, 000;
  - release pulses 000, 000, 001;
  - each pulse exactly 1 clk40MHz cycle.
- Reset mid-transfer: assert rst 5 clk40MHz cycles immediately after src_valid(x=300) → no update, outputs 0. A later sample x=50 → update, x=50, drop_cnt=0.
- Saturation: 300 overwrites while ack is held back (force slow destination) → drop_cnt = 255, with no wrap.
